// File: rtl/icyrisc_pkg.sv
// Shared encodings for the IcyRisc multi-cycle control path: FSM states,
// ALU operation codes, datapath select codes and RV32I opcodes.
package icyrisc_pkg;

    typedef enum logic [3:0] {
        S_RESET    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_EXEC_LUI = 4'd5,
        S_ALU_WB   = 4'd6,
        S_MEM_ADDR = 4'd7,
        S_MEM_RD   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_MEM_WB   = 4'd10,
        S_BRANCH   = 4'd11,
        S_JALR_TGT = 4'd12,
        S_JUMP     = 4'd13,
        S_TRAP     = 4'd14
    } ctrl_state_t;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'd0,
        ALU_SUB    = 4'd1,
        ALU_AND    = 4'd2,
        ALU_OR     = 4'd3,
        ALU_XOR    = 4'd4,
        ALU_SLT    = 4'd5,
        ALU_SLTU   = 4'd6,
        ALU_SLL    = 4'd7,
        ALU_SRL    = 4'd8,
        ALU_SRA    = 4'd9,
        ALU_PASS_B = 4'd11
    } alu_op_t;

    typedef enum logic [1:0] {
        SRC1_PC     = 2'd0,
        SRC1_PC_OLD = 2'd1,
        SRC1_RS1    = 2'd2
    } alu_src1_t;

    typedef enum logic [1:0] {
        SRC2_RS2  = 2'd0,
        SRC2_IMM  = 2'd1,
        SRC2_FOUR = 2'd2
    } alu_src2_t;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_t;

    typedef enum logic [1:0] {
        RES_ALUOUT = 2'd0,
        RES_MEM    = 2'd1,
        RES_ALU    = 2'd2
    } result_sel_t;

    // Instruction class seen by the ALU operation decoder.
    typedef enum logic [1:0] {
        CLS_R      = 2'd0,
        CLS_I      = 2'd1,
        CLS_BRANCH = 2'd2
    } alu_class_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    function automatic imm_type_t imm_type_of(input logic [6:0] op);
        imm_type_t t;
        t = IMM_I;
        case (op)
            OP_STORE:         t = IMM_S;
            OP_BRANCH:        t = IMM_B;
            OP_LUI, OP_AUIPC: t = IMM_U;
            OP_JAL:           t = IMM_J;
            default:          t = IMM_I;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/core_ctrl_fsm_if.sv
// Request/acknowledge handshake between the control FSM and unified memory.
interface core_ctrl_fsm_if;

    logic mem_req;
    logic mem_we;
    logic mem_addr_sel;
    logic mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr_sel,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr_sel,
        output mem_ack
    );

endinterface

// File: rtl/alu_op_decoder.sv
// Combinational mapping of instruction class, funct3 and funct7[5] to the
// ALU operation code used by register, immediate and branch instructions.
module alu_op_decoder
    import icyrisc_pkg::*;
(
    input  alu_class_t  alu_class,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    output alu_op_t     alu_op
);

    always_comb begin
        // NOTE: default assignment first so no path leaves alu_op unassigned (no latch).
        alu_op = ALU_ADD;
        if (alu_class == CLS_BRANCH) begin
            // Equality branches subtract; ordered branches compare signed/unsigned.
            case (funct3[2:1])
                2'b10:   alu_op = ALU_SLT;
                2'b11:   alu_op = ALU_SLTU;
                default: alu_op = ALU_SUB;
            endcase
        end else begin
            case (funct3)
                3'b000:  alu_op = (alu_class == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
                3'b001:  alu_op = ALU_SLL;
                3'b010:  alu_op = ALU_SLT;
                3'b011:  alu_op = ALU_SLTU;
                3'b100:  alu_op = ALU_XOR;
                3'b101:  alu_op = funct7_5 ? ALU_SRA : ALU_SRL;
                3'b110:  alu_op = ALU_OR;
                default: alu_op = ALU_AND;
            endcase
        end
    end

endmodule

// File: rtl/core_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences the shared ALU, datapath enables
// and the memory handshake for one instruction at a time.
module core_ctrl_fsm
    import icyrisc_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [6:0]      opcode,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [1:0]      zero,
    core_ctrl_fsm_if.master mem,
    output logic            ir_we,
    output logic            pc_we,
    output logic            pc_src_sel,
    output logic            reg_we,
    output logic [1:0]      result_sel,
    output logic [2:0]      imm_sel,
    output logic [1:0]      ALU_src1_sel,
    output logic [1:0]      ALU_src2_sel,
    output logic [3:0]      ALU_ctrl,
    output logic            illegal,
    output logic [31:0]     instret
);

    ctrl_state_t state;
    ctrl_state_t state_nxt;
    alu_class_t  alu_class;
    alu_op_t     dec_op;
    logic        branch_taken;

    alu_src1_t   src1;
    alu_src2_t   src2;
    alu_op_t     alu_op;
    imm_type_t   imm;
    result_sel_t res;
    logic        mem_req_c;
    logic        mem_we_c;
    logic        mem_addr_sel_c;

    assign alu_class = (opcode == OP_BRANCH) ? CLS_BRANCH :
                       (opcode == OP_R)      ? CLS_R      : CLS_I;

    alu_op_decoder u_alu_op_decoder (
        .alu_class (alu_class),
        .funct3    (funct3),
        .funct7_5  (funct7_5),
        .alu_op    (dec_op)
    );

    // funct3[2] picks the less-than flag over the equality flag; funct3[0] inverts.
    assign branch_taken = (funct3[2] ? zero[1] : zero[0]) ^ funct3[0];

    always_comb begin
        state_nxt = state;
        case (state)
            S_RESET:    state_nxt = S_FETCH;
            S_FETCH:    if (mem.mem_ack) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_IMM:            state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                    OP_BRANCH:         state_nxt = (funct3[2:1] == 2'b01) ? S_TRAP : S_BRANCH;
                    OP_JAL:            state_nxt = S_JUMP;
                    OP_JALR:           state_nxt = S_JALR_TGT;
                    OP_LUI:            state_nxt = S_EXEC_LUI;
                    OP_AUIPC:          state_nxt = S_ALU_WB;
                    default:           state_nxt = S_TRAP;
                endcase
            end
            S_EXEC_R, S_EXEC_I, S_EXEC_LUI: state_nxt = S_ALU_WB;
            S_MEM_ADDR: state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem.mem_ack) state_nxt = S_MEM_WB;
            S_MEM_WR:   if (mem.mem_ack) state_nxt = S_FETCH;
            S_ALU_WB, S_MEM_WB, S_BRANCH, S_JUMP: state_nxt = S_FETCH;
            S_JALR_TGT: state_nxt = S_JUMP;
            S_TRAP:     state_nxt = S_TRAP;
            default:    state_nxt = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_RESET;
            illegal <= 1'b0;
            instret <= 32'd0;
        end else begin
            // NOTE: non-blocking for all state so every register samples pre-edge values.
            state <= state_nxt;
            if (state_nxt == S_TRAP) illegal <= 1'b1;
            // An instruction retires on its final cycle, i.e. when it hands back to FETCH.
            if (state_nxt == S_FETCH && state != S_RESET && state != S_FETCH)
                instret <= instret + 32'd1;
        end
    end

    always_comb begin
        mem_req_c      = 1'b0;
        mem_we_c       = 1'b0;
        mem_addr_sel_c = 1'b0;
        ir_we          = 1'b0;
        pc_we          = 1'b0;
        pc_src_sel     = 1'b0;
        reg_we         = 1'b0;
        res            = RES_ALUOUT;
        imm            = IMM_I;
        src1           = SRC1_PC;
        src2           = SRC2_RS2;
        alu_op         = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_req_c = 1'b1;
                src2      = SRC2_FOUR;
                if (mem.mem_ack) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                end
            end
            S_DECODE: begin
                src1 = SRC1_PC_OLD;
                src2 = SRC2_IMM;
                imm  = imm_type_of(opcode);
            end
            S_EXEC_R: begin
                src1   = SRC1_RS1;
                alu_op = dec_op;
            end
            S_EXEC_I: begin
                src1   = SRC1_RS1;
                src2   = SRC2_IMM;
                alu_op = dec_op;
            end
            S_EXEC_LUI: begin
                src2   = SRC2_IMM;
                imm    = IMM_U;
                alu_op = ALU_PASS_B;
            end
            S_ALU_WB: reg_we = 1'b1;
            S_MEM_ADDR: begin
                src1 = SRC1_RS1;
                src2 = SRC2_IMM;
                imm  = (opcode == OP_STORE) ? IMM_S : IMM_I;
            end
            S_MEM_RD, S_MEM_WR: begin
                mem_req_c      = 1'b1;
                mem_addr_sel_c = 1'b1;
                mem_we_c       = (state == S_MEM_WR);
            end
            S_MEM_WB: begin
                reg_we = 1'b1;
                res    = RES_MEM;
            end
            S_BRANCH: begin
                src1       = SRC1_RS1;
                alu_op     = dec_op;
                pc_we      = branch_taken;
                pc_src_sel = 1'b1;
            end
            S_JALR_TGT: begin
                src1 = SRC1_RS1;
                src2 = SRC2_IMM;
            end
            S_JUMP: begin
                src1       = SRC1_PC_OLD;
                src2       = SRC2_FOUR;
                reg_we     = 1'b1;
                res        = RES_ALU;
                pc_we      = 1'b1;
                pc_src_sel = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem.mem_req      = mem_req_c;
    assign mem.mem_we       = mem_we_c;
    assign mem.mem_addr_sel = mem_addr_sel_c;
    assign result_sel       = res;
    assign imm_sel          = imm;
    assign ALU_src1_sel     = src1;
    assign ALU_src2_sel     = src2;
    assign ALU_ctrl         = alu_op;

endmodule

// File: tb/tb_core_ctrl_fsm.sv
// Scoreboard bench for core_ctrl_fsm: per-instruction expected cycle traces
// are queued by the stimulus and compared by an independent negedge monitor.
module tb_core_ctrl_fsm;

    localparam logic [6:0] OPC_R     = 7'b0110011;
    localparam logic [6:0] OPC_I     = 7'b0010011;
    localparam logic [6:0] OPC_LD    = 7'b0000011;
    localparam logic [6:0] OPC_ST    = 7'b0100011;
    localparam logic [6:0] OPC_BR    = 7'b1100011;
    localparam logic [6:0] OPC_JAL   = 7'b1101111;
    localparam logic [6:0] OPC_JALR  = 7'b1100111;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [1:0]  zero;
    logic        ir_we, pc_we, pc_src_sel, reg_we, illegal;
    logic [1:0]  result_sel, ALU_src1_sel, ALU_src2_sel;
    logic [2:0]  imm_sel;
    logic [3:0]  ALU_ctrl;
    logic [31:0] instret;

    core_ctrl_fsm_if bus ();

    core_ctrl_fsm dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .opcode       (opcode),
        .funct3       (funct3),
        .funct7_5     (funct7_5),
        .zero         (zero),
        .mem          (bus),
        .ir_we        (ir_we),
        .pc_we        (pc_we),
        .pc_src_sel   (pc_src_sel),
        .reg_we       (reg_we),
        .result_sel   (result_sel),
        .imm_sel      (imm_sel),
        .ALU_src1_sel (ALU_src1_sel),
        .ALU_src2_sel (ALU_src2_sel),
        .ALU_ctrl     (ALU_ctrl),
        .illegal      (illegal),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        mem_req;
        logic        mem_we;
        logic        mem_addr_sel;
        logic        ir_we;
        logic        pc_we;
        logic        pc_src_sel;
        logic        reg_we;
        logic [1:0]  result_sel;
        logic [2:0]  imm_sel;
        logic [1:0]  src1;
        logic [1:0]  src2;
        logic [3:0]  ctrl;
        logic        illegal;
        logic [31:0] instret;
    } out_t;

    typedef struct {
        out_t  exp;
        out_t  mask;
        string tag;
    } rec_t;

    rec_t exp_q[$];
    rec_t bld_q[$];
    bit   bld_ack[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   retired = 0;

    function automatic out_t sample();
        out_t s;
        s.mem_req      = bus.mem_req;
        s.mem_we       = bus.mem_we;
        s.mem_addr_sel = bus.mem_addr_sel;
        s.ir_we        = ir_we;
        s.pc_we        = pc_we;
        s.pc_src_sel   = pc_src_sel;
        s.reg_we       = reg_we;
        s.result_sel   = result_sel;
        s.imm_sel      = imm_sel;
        s.src1         = ALU_src1_sel;
        s.src2         = ALU_src2_sel;
        s.ctrl         = ALU_ctrl;
        s.illegal      = illegal;
        s.instret      = instret;
        return s;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("req=%b we=%b asel=%b ir_we=%b pc_we=%b pc_src=%b reg_we=%b res=%0d imm=%0d src=%0d/%0d alu=%0d ill=%b instret=%0d",
                         o.mem_req, o.mem_we, o.mem_addr_sel, o.ir_we, o.pc_we, o.pc_src_sel, o.reg_we,
                         o.result_sel, o.imm_sel, o.src1, o.src2, o.ctrl, o.illegal, o.instret);
    endfunction

    // Fields that only matter alongside their qualifier are ignored otherwise.
    function automatic out_t care_of(input out_t e);
        out_t m;
        m = '1;
        if (!e.mem_req) begin
            m.mem_we       = 1'b0;
            m.mem_addr_sel = 1'b0;
        end
        if (!e.pc_we)         m.pc_src_sel = 1'b0;
        if (!e.reg_we)        m.result_sel = 2'b0;
        if (e.src2 != 2'd1)   m.imm_sel    = 3'b0;
        return m;
    endfunction

    task automatic check(input string name, input out_t act, input out_t exp, input out_t mask);
        out_t a;
        out_t w;
        a = act & mask;
        w = exp & mask;
        vectors++;
        if (a !== w) begin
            miscompares++;
            $display("FAIL %s: got {%s} want {%s}", name, fmt(a), fmt(w));
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            rec_t r;
            r = exp_q.pop_front();
            check(r.tag, sample(), r.exp, r.mask);
        end
    end

    function automatic logic [3:0] alu_ref(input bit is_r, input logic [2:0] f3, input logic f7);
        logic [3:0] tbl [8];
        logic [3:0] r;
        tbl = '{4'd0, 4'd7, 4'd5, 4'd6, 4'd4, 4'd8, 4'd3, 4'd2};
        r = tbl[f3];
        if (f3 == 3'd0 && is_r && f7) r = 4'd1;
        if (f3 == 3'd5 && f7)         r = 4'd9;
        return r;
    endfunction

    function automatic logic [3:0] br_ctrl(input logic [2:0] f3);
        case (f3)
            3'd0, 3'd1: return 4'd1;
            3'd4, 3'd5: return 4'd5;
            default:    return 4'd6;
        endcase
    endfunction

    function automatic bit br_taken(input logic [2:0] f3, input logic [1:0] z);
        case (f3)
            3'd0:       return z[0];
            3'd1:       return !z[0];
            3'd4, 3'd6: return z[1];
            default:    return !z[1];
        endcase
    endfunction

    // Immediate type chosen in DECODE; -1 where the opcode carries no immediate.
    function automatic int imm_ref(input logic [6:0] op);
        case (op)
            OPC_I, OPC_LD, OPC_JALR: return 0;
            OPC_ST:                  return 1;
            OPC_BR:                  return 2;
            OPC_LUI, OPC_AUIPC:      return 3;
            OPC_JAL:                 return 4;
            default:                 return -1;
        endcase
    endfunction

    function automatic out_t base();
        out_t e;
        e = '0;
        e.instret = retired;
        return e;
    endfunction

    task automatic add(input out_t e, input out_t m, input bit a, input string tag);
        rec_t r;
        r.exp  = e;
        r.mask = m;
        r.tag  = tag;
        bld_q.push_back(r);
        bld_ack.push_back(a);
    endtask

    task automatic add_jump(input string tag);
        out_t e;
        e = base();
        e.src1 = 2'd1; e.src2 = 2'd2; e.reg_we = 1'b1; e.result_sel = 2'd2;
        e.pc_we = 1'b1; e.pc_src_sel = 1'b1;
        add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".jump"});
    endtask

    task automatic add_wb(input string tag, input logic [1:0] sel);
        out_t e;
        e = base();
        e.reg_we = 1'b1; e.result_sel = sel;
        add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".wb"});
    endtask

    // Builds the expected trace for one instruction, queues it, then drives it.
    task automatic run_instr(input string tag, input logic [6:0] op, input logic [2:0] f3,
                             input logic f7, input logic [1:0] z, input int fw, input int mw);
        out_t e;
        out_t m;
        int   imm;
        bit   legal;
        legal = 1'b1;
        for (int k = 0; k <= fw; k++) begin
            e = base();
            e.mem_req = 1'b1; e.src2 = 2'd2;
            if (k == fw) begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            add(e, care_of(e), k == fw, {tag, ".fetch"});
        end
        e = base();
        e.src1 = 2'd1; e.src2 = 2'd1;
        imm = imm_ref(op);
        e.imm_sel = (imm < 0) ? 3'd0 : 3'(imm);
        m = care_of(e);
        if (imm < 0) m.imm_sel = 3'b0;
        add(e, m, bit'($urandom_range(0, 1)), {tag, ".decode"});
        case (op)
            OPC_R, OPC_I: begin
                e = base();
                e.src1 = 2'd2; e.src2 = (op == OPC_I) ? 2'd1 : 2'd0; e.imm_sel = 3'd0;
                e.ctrl = alu_ref(op == OPC_R, f3, f7);
                add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".exec"});
                add_wb(tag, 2'd0);
            end
            OPC_LUI: begin
                e = base();
                e.src2 = 2'd1; e.imm_sel = 3'd3; e.ctrl = 4'd11;
                add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".exec"});
                add_wb(tag, 2'd0);
            end
            OPC_AUIPC: add_wb(tag, 2'd0);
            OPC_LD, OPC_ST: begin
                e = base();
                e.src1 = 2'd2; e.src2 = 2'd1; e.imm_sel = (op == OPC_ST) ? 3'd1 : 3'd0;
                add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".addr"});
                for (int k = 0; k <= mw; k++) begin
                    e = base();
                    e.mem_req = 1'b1; e.mem_addr_sel = 1'b1; e.mem_we = (op == OPC_ST);
                    add(e, care_of(e), k == mw, {tag, ".mem"});
                end
                if (op == OPC_LD) add_wb(tag, 2'd1);
            end
            OPC_BR: begin
                if (f3 == 3'd2 || f3 == 3'd3) begin
                    legal = 1'b0;
                end else begin
                    e = base();
                    e.src1 = 2'd2; e.ctrl = br_ctrl(f3);
                    if (br_taken(f3, z)) begin e.pc_we = 1'b1; e.pc_src_sel = 1'b1; end
                    add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".branch"});
                end
            end
            OPC_JALR: begin
                e = base();
                e.src1 = 2'd2; e.src2 = 2'd1; e.imm_sel = 3'd0;
                add(e, care_of(e), bit'($urandom_range(0, 1)), {tag, ".tgt"});
                add_jump(tag);
            end
            OPC_JAL: add_jump(tag);
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            for (int k = 0; k < 100; k++) begin
                e = base();
                e.illegal = 1'b1;
                add(e, '1, bit'($urandom_range(0, 1)), {tag, ".trap"});
            end
        end
        foreach (bld_q[i]) exp_q.push_back(bld_q[i]);
        for (int i = 0; i < bld_q.size(); i++) begin
            if (i == fw + 1) begin
                opcode = op; funct3 = f3; funct7_5 = f7; zero = z;
            end
            bus.mem_ack = bld_ack[i];
            @(posedge clk);
            #1;
        end
        bld_q.delete();
        bld_ack.delete();
        if (legal) retired++;
    endtask

    // Leaves the bench 1 time unit after the edge that enters the first FETCH.
    task automatic do_reset();
        out_t zz;
        zz = '0;
        rst_n = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", sample(), zz, '1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        retired = 0;
        @(negedge clk);
        check("reset_idle_cycle", sample(), zz, '1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] kinds [9];
        out_t e;
        out_t zz;
        zz = '0;
        kinds = '{OPC_R, OPC_I, OPC_LD, OPC_ST, OPC_BR, OPC_JAL, OPC_JALR, OPC_LUI, OPC_AUIPC};
        opcode = '0; funct3 = '0; funct7_5 = 1'b0; zero = '0; bus.mem_ack = 1'b0;

        do_reset();
        run_instr("add_w3",  OPC_R,    3'd0, 1'b0, 2'b00, 3, 0);
        run_instr("sub",     OPC_R,    3'd0, 1'b1, 2'b00, 0, 0);
        run_instr("srai",    OPC_I,    3'd5, 1'b1, 2'b00, 0, 0);
        run_instr("addi_f7", OPC_I,    3'd0, 1'b1, 2'b00, 1, 0);
        run_instr("sltiu",   OPC_I,    3'd3, 1'b0, 2'b00, 0, 0);
        run_instr("bne_nt",  OPC_BR,   3'd1, 1'b0, 2'b01, 0, 0);
        run_instr("bne_t",   OPC_BR,   3'd1, 1'b0, 2'b00, 0, 0);
        run_instr("bltu_t",  OPC_BR,   3'd6, 1'b0, 2'b10, 0, 0);
        run_instr("bltu_nt", OPC_BR,   3'd6, 1'b0, 2'b01, 0, 0);
        run_instr("lw",      OPC_LD,   3'd2, 1'b0, 2'b00, 1, 2);
        run_instr("sw",      OPC_ST,   3'd2, 1'b0, 2'b00, 0, 0);
        run_instr("jal",     OPC_JAL,  3'd0, 1'b0, 2'b00, 0, 0);
        run_instr("jalr",    OPC_JALR, 3'd0, 1'b0, 2'b00, 2, 0);
        run_instr("lui",     OPC_LUI,  3'd0, 1'b0, 2'b00, 0, 0);
        run_instr("auipc",   OPC_AUIPC,3'd0, 1'b0, 2'b00, 0, 0);

        for (int n = 0; n < 300; n++) begin
            logic [6:0] op;
            logic [2:0] f3;
            op = kinds[$urandom_range(0, 8)];
            f3 = 3'($urandom_range(0, 7));
            if (op == OPC_BR && f3[2:1] == 2'b01) f3[2] = 1'b1;
            run_instr("rand", op, f3, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      $urandom_range(0, 2), $urandom_range(0, 2));
        end

        run_instr("illegal_op", 7'b0000000, 3'd0, 1'b0, 2'b00, 0, 0);
        do_reset();
        run_instr("add_after_trap", OPC_R, 3'd7, 1'b0, 2'b00, 0, 0);
        run_instr("br_reserved", OPC_BR, 3'd2, 1'b0, 2'b00, 1, 0);

        // Reset dropped while a fetch request is outstanding.
        do_reset();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        e = base();
        e.mem_req = 1'b1; e.src2 = 2'd2;
        check("fetch_waiting", sample(), e, care_of(e));
        #2 rst_n = 1'b0;
        #1 check("reset_mid_fetch", sample(), zz, '1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
